// File: rtl/life_gen_if.sv
// life_gen_if: life generator bus (timing inputs, seeding write handshake, display read, status outputs)
interface life_gen_if;
  logic frame_tick, run, step_req;
  logic wr_valid, wr_ready, wr_alive;
  logic [4:0] wr_x, rd_x;
  logic [3:0] wr_y, rd_y;
  logic rd_alive, busy, gen_done;
  logic [15:0] gen_count;
  modport master (
    output frame_tick, run, step_req, wr_valid, wr_x, wr_y, wr_alive, rd_x, rd_y,
    input wr_ready, rd_alive, busy, gen_done, gen_count
  );
  modport slave (
    input frame_tick, run, step_req, wr_valid, wr_x, wr_y, wr_alive, rd_x, rd_y,
    output wr_ready, rd_alive, busy, gen_done, gen_count
  );
endinterface

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: double-buffered Game of Life sequencer (clk, rst, bus: seed writes, display reads, step/auto-run, busy/gen_done/gen_count)
module life_gen_ctrl #(
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int GEN_DIV = 30
) (
  input logic clk,
  input logic rst,
  life_gen_if.slave bus
);
  localparam int N = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int DW = GEN_DIV > 1 ? $clog2(GEN_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;
  state_t state;
  logic [N-1:0] b0, b1, disp;
  logic sel, pend, fire, go, nv, last_x, wr_in;
  logic [DW-1:0] div;
  logic [4:0] cx, xm, xp;
  logic [3:0] cy, ym, yp, n;
  function automatic logic [AW-1:0] idx(input logic [4:0] x, input logic [3:0] y);
    return AW'(int'(y) * COLS + int'(x));
  endfunction
  assign disp = sel ? b1 : b0;
  assign bus.busy = state != IDLE;
  assign bus.wr_ready = state == IDLE;
  assign bus.rd_alive = (int'(bus.rd_x) < COLS && int'(bus.rd_y) < ROWS) ? disp[idx(bus.rd_x, bus.rd_y)] : 1'b0;
  assign wr_in = int'(bus.wr_x) < COLS && int'(bus.wr_y) < ROWS;
  always_comb begin
    xm = cx == 5'd0 ? 5'(COLS - 1) : cx - 5'd1;
    xp = cx == 5'(COLS - 1) ? 5'd0 : cx + 5'd1;
    ym = cy == 4'd0 ? 4'(ROWS - 1) : cy - 4'd1;
    yp = cy == 4'(ROWS - 1) ? 4'd0 : cy + 4'd1;
    n = 4'(disp[idx(xm, ym)]) + 4'(disp[idx(cx, ym)]) + 4'(disp[idx(xp, ym)])
      + 4'(disp[idx(xm, cy)]) + 4'(disp[idx(xp, cy)])
      + 4'(disp[idx(xm, yp)]) + 4'(disp[idx(cx, yp)]) + 4'(disp[idx(xp, yp)]);
    nv = n == 4'd3 || (disp[idx(cx, cy)] && n == 4'd2);
    last_x = cx == 5'(COLS - 1);
    fire = bus.run && bus.frame_tick && div == DW'(GEN_DIV - 1);
    go = state == IDLE && (pend || bus.step_req || fire) && !bus.wr_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      b0 <= '0;
      b1 <= '0;
      sel <= 1'b0;
      pend <= 1'b0;
      div <= '0;
      cx <= '0;
      cy <= '0;
      bus.gen_done <= 1'b0;
      bus.gen_count <= '0;
    end else begin
      bus.gen_done <= state == SWAP;
      div <= (!bus.run || fire) ? '0 : bus.frame_tick ? div + 1'b1 : div;
      pend <= !go && (pend || bus.step_req || fire);
      if (bus.wr_valid && state == IDLE && wr_in) begin
        if (sel) b1[idx(bus.wr_x, bus.wr_y)] <= bus.wr_alive;
        else b0[idx(bus.wr_x, bus.wr_y)] <= bus.wr_alive;
      end
      if (go) begin
        state <= SCAN;
        cx <= '0;
        cy <= '0;
      end else if (state == SCAN) begin
        if (sel) b0[idx(cx, cy)] <= nv;
        else b1[idx(cx, cy)] <= nv;
        cx <= last_x ? 5'd0 : cx + 5'd1;
        cy <= last_x ? cy + 4'd1 : cy;
        if (last_x && cy == 4'(ROWS - 1)) state <= SWAP;
      end else if (state == SWAP) begin
        sel <= ~sel;
        bus.gen_count <= bus.gen_count + 16'd1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: scoreboard bench for life_gen_ctrl with directed patterns
`timescale 1ns/100ps
module tb_life_gen_ctrl;
  localparam int N = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  life_gen_if b();
  life_gen_ctrl #(.GEN_DIV(2)) dut (.clk(clk), .rst(rst), .bus(b));
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int busy_len = 0;
  int exp_cnt;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int c(input int x, input int y);
    return y * 20 + x;
  endfunction
  function automatic logic [N-1:0] grid3(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
    logic [N-1:0] g;
    g = '0;
    g[c(x0, y0)] = 1'b1;
    g[c(x1, y1)] = 1'b1;
    g[c(x2, y2)] = 1'b1;
    return g;
  endfunction
  always @(negedge clk) begin
    if (rst) busy_len = 0;
    else if (b.gen_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_gen_done: gen_count=%0d with no generation expected", b.gen_count);
      end else begin
        exp_cnt = exp_q.pop_front();
        chk("gen_count_at_done", 32'(b.gen_count), exp_cnt);
        chk("busy_cycles", busy_len, 301);
      end
      busy_len = 0;
    end else busy_len = b.busy ? busy_len + 1 : 0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int x, input int y, input logic a);
    b.wr_x = 5'(x);
    b.wr_y = 4'(y);
    b.wr_alive = a;
    b.wr_valid = 1'b1;
    tick();
    b.wr_valid = 1'b0;
  endtask
  task automatic step();
    b.step_req = 1'b1;
    tick();
    b.step_req = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || b.busy) && k < 2000) begin
      tick();
      k++;
    end
    chk({nm, "_in_time"}, 32'(k < 2000), 1);
  endtask
  task automatic rd_chk(input string nm, input int x, input int y, input logic exp);
    b.rd_x = 5'(x);
    b.rd_y = 4'(y);
    #1;
    chk(nm, 32'(b.rd_alive), 32'(exp));
  endtask
  task automatic check_grid(input string nm, input logic [N-1:0] exp);
    logic [N-1:0] got;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 20; x++) begin
        b.rd_x = 5'(x);
        b.rd_y = 4'(y);
        #1;
        got[c(x, y)] = b.rd_alive;
      end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  initial begin
    b.frame_tick = 1'b0;
    b.run = 1'b0;
    b.step_req = 1'b0;
    b.wr_valid = 1'b0;
    b.wr_x = '0;
    b.wr_y = '0;
    b.wr_alive = 1'b0;
    b.rd_x = '0;
    b.rd_y = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(b.busy), 0);
    chk("reset_wr_ready", 32'(b.wr_ready), 1);
    chk("reset_gen_count", 32'(b.gen_count), 0);
    chk("reset_gen_done", 32'(b.gen_done), 0);
    check_grid("reset_grid", '0);
    wr(20, 0, 1'b1);
    wr(3, 15, 1'b1);
    wr(31, 14, 1'b1);
    check_grid("oob_write_grid", '0);
    wr(5, 5, 1'b1);
    wr(6, 5, 1'b1);
    wr(7, 5, 1'b1);
    rd_chk("rd_in_range", 6, 5, 1'b1);
    rd_chk("rd_x_oob", 25, 4, 1'b0);
    rd_chk("rd_y_oob", 5, 15, 1'b0);
    exp_q.push_back(1);
    step();
    chk("busy_after_step", 32'(b.busy), 1);
    chk("wr_ready_busy", 32'(b.wr_ready), 0);
    wait_idle("blinker1");
    check_grid("blinker_gen1", grid3(6, 4, 6, 5, 6, 6));
    chk("blinker_count1", 32'(b.gen_count), 1);
    exp_q.push_back(2);
    step();
    wait_idle("blinker2");
    check_grid("blinker_gen2", grid3(5, 5, 6, 5, 7, 5));
    chk("blinker_count2", 32'(b.gen_count), 2);
    wr(5, 5, 1'b0);
    wr(6, 5, 1'b0);
    wr(7, 5, 1'b0);
    wr(19, 0, 1'b1);
    wr(0, 0, 1'b1);
    wr(1, 0, 1'b1);
    exp_q.push_back(3);
    step();
    wait_idle("wrap");
    check_grid("wrap_gen", grid3(0, 14, 0, 0, 0, 1));
    exp_q.push_back(4);
    exp_q.push_back(5);
    step();
    repeat (50) tick();
    b.wr_x = 5'd0;
    b.wr_y = 4'd0;
    b.wr_alive = 1'b0;
    b.wr_valid = 1'b1;
    chk("wr_ready_in_scan", 32'(b.wr_ready), 0);
    tick();
    b.wr_valid = 1'b0;
    repeat (50) tick();
    step();
    repeat (10) tick();
    step();
    begin
      int k;
      k = 0;
      while (!b.gen_done && k < 1000) begin
        @(negedge clk);
        k++;
      end
      chk("gen4_done_seen", 32'(k < 1000), 1);
      @(negedge clk);
      chk("extra_gen_immediate", 32'(b.busy), 1);
    end
    wait_idle("coalesce");
    check_grid("scan_write_ignored", grid3(0, 14, 0, 0, 0, 1));
    chk("coalesce_count", 32'(b.gen_count), 5);
    b.wr_x = 5'd0;
    b.wr_y = 4'd0;
    b.wr_alive = 1'b0;
    b.wr_valid = 1'b1;
    b.step_req = 1'b1;
    exp_q.push_back(6);
    tick();
    b.wr_valid = 1'b0;
    b.step_req = 1'b0;
    chk("write_defers_start", 32'(b.busy), 0);
    tick();
    chk("start_after_write", 32'(b.busy), 1);
    wait_idle("write_step");
    check_grid("write_then_scan", '0);
    wr(5, 5, 1'b1);
    wr(6, 5, 1'b1);
    wr(7, 5, 1'b1);
    exp_q.push_back(7);
    exp_q.push_back(8);
    exp_q.push_back(9);
    b.run = 1'b1;
    for (int t = 0; t < 6; t++) begin
      b.frame_tick = 1'b1;
      tick();
      b.frame_tick = 1'b0;
      repeat (399) tick();
    end
    wait_idle("autorun");
    chk("autorun_count", 32'(b.gen_count), 9);
    check_grid("autorun_grid", grid3(6, 4, 6, 5, 6, 6));
    b.run = 1'b0;
    for (int t = 0; t < 2; t++) begin
      b.frame_tick = 1'b1;
      tick();
      b.frame_tick = 1'b0;
      repeat (399) tick();
    end
    chk("run_off_count", 32'(b.gen_count), 9);
    chk("run_off_busy", 32'(b.busy), 0);
    step();
    repeat (99) tick();
    chk("abort_in_scan", 32'(b.busy), 1);
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(b.busy), 0);
    chk("abort_gen_done", 32'(b.gen_done), 0);
    chk("abort_gen_count", 32'(b.gen_count), 0);
    rst = 1'b0;
    check_grid("abort_grid", '0);
    repeat (400) tick();
    chk("abort_no_gen", 32'(b.gen_count), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
